led_mode_sequencer: RTL and testbench
=====================================

Name: led_mode_sequencer

Overview:
- Front-end controller for the 4-bit LED shifter datapath. It owns the 2-bit mode code (00 clear, 01 shift-left, 10 shift-right, 11 all-on) and a step strobe at human-visible rate.
- Debounces the raw board switches and an auto-demo switch.
- Arbitrates between manual switch control and an autonomous demo schedule that cycles through all four modes.
- Sits between board I/O pins and the shifter's mode/step inputs.

Parameters:
- TICK_DIV, 50_000_000: clk cycles per led_step pulse; must be >= 2.
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a switch change; must be >= 1.
- STEPS, 8: led_step ticks spent in each auto phase; must be >= 1.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- sw_raw  in  2  raw mode switches, asynchronous to clk
- auto_raw  in  1  raw auto-demo enable switch, asynchronous to clk
- led_sw  out  2  mode code to shifter
- led_step  out  1  one-cycle step strobe to shifter
- auto_active  out  1  high while in any AUTO_* state
- lockout  out  1  high while auto re-entry is blocked

Behaviour:
- Reset: rst is synchronous and active-high; clock is clk. On reset:
  - all synchronisers, debounce counters and debounced values clear to 0
  - tick counter and phase counter clear to 0
  - state goes to MANUAL; lockout clears to 0
  - outputs: led_sw=00, led_step=0, auto_active=0, lockout=0
  - Reset mid-auto aborts immediately, with no completion of the current phase.
- Synchroniser: each of sw_raw[1:0] and auto_raw passes through 2 flops.
- Debouncer (one per bit):
  - Counter clears while the synced value equals the debounced value.
  - Otherwise it increments each cycle.
  - When the counter equals DB_CYCLES-1 and the values still differ, the debounced value takes the synced value and the counter clears.
  - Net latency: a raw change held stable updates the debounced value at rising edge DB_CYCLES+2 after it is first sampled.
  - A glitch shorter than DB_CYCLES cycles never propagates.
- Tick generator:
  - Counter runs 0..TICK_DIV-1 and wraps.
  - led_step=1 for exactly the cycle in which the counter equals TICK_DIV-1.
  - It runs in all states.
  - It clears to 0 on the MANUAL->AUTO_L transition, so the first auto phase lasts exactly STEPS*TICK_DIV cycles.
- FSM states: MANUAL, AUTO_L (led_sw=01), AUTO_R (10), AUTO_ON (11), AUTO_OFF (00).
- MANUAL:
  - led_sw = debounced sw.
  - Go to AUTO_L when debounced auto=1 and lockout=0; the phase counter clears on entry.
  - lockout clears whenever debounced auto=0.
- AUTO_*: transitions are evaluated in this priority order:
  1. Debounced auto=0 -> MANUAL.
  2. Debounced sw changes value (manual override) -> MANUAL and lockout<=1. Auto is re-entered only after auto is deasserted and reasserted.
  3. On led_step with phase counter = STEPS-1 -> next state in the order L->R->ON->OFF->L, and the phase counter clears.
  4. Otherwise, on led_step the phase counter increments.
- Phase counter width is clog2(STEPS), minimum 1 bit.
- Output timing:
  - led_sw is a decode of registered state and registered debounced sw, with no combinational path from raw inputs.
  - led_sw changes on the same edge as the state change.
  - auto_active = (state != MANUAL).
- Simultaneous events:
  - An auto drop and a phase-end tick in the same cycle -> MANUAL.
  - An sw change and a phase-end tick in the same cycle -> MANUAL with lockout.
  - led_step still pulses in those cycles.

Test Plan:
All scenarios use TICK_DIV=4, DB_CYCLES=3, STEPS=2.
1. Reset check: rst high 2 cycles with sw_raw=11 and auto_raw=1 -> led_sw=00, led_step=0, auto_active=0 and lockout=0 during reset and on the first cycle after.
2. Debounce: sw_raw=01 held -> led_sw=01 from edge 5 after sampling. A 2-cycle pulse of sw_raw=10 -> led_sw stays 01.
3. Tick: idle in MANUAL -> led_step high 1 cycle in every 4, with 3 low cycles between pulses.
4. Auto schedule: auto_raw=1 with sw held 00 -> after debounce, led_sw sequence 01,10,11,00,01, with each value held 8 cycles and auto_active=1 throughout.
5. Override and lockout: change sw_raw to 11 during AUTO_R -> MANUAL with led_sw=11 and lockout=1, and no re-entry while auto_raw stays 1. Then toggle auto_raw 0 then 1 (each held >3 cycles) -> lockout=0 and AUTO_L restarts with led_sw=01.
6. Reset mid-operation: rst asserted during AUTO_ON at phase count 1 -> next cycle state MANUAL, led_sw=00. After release with auto_raw=1, AUTO_L re-enters after 5 cycles of debounce.

Source files
------------

// File: rtl/led_mode_sequencer.sv
// Purpose: debounces board switches and sequences the LED shifter mode code, manually or via an auto demo.
// Latency: switch changes appear on led_sw DB_CYCLES+2 edges after first sample; led_step every TICK_DIV cycles.
// Backpressure: none; the shifter consumes led_sw/led_step unconditionally.
module led_mode_sequencer #(
  parameter int TICK_DIV  = 50_000_000,
  parameter int DB_CYCLES = 1_000_000,
  parameter int STEPS     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] sw_raw,
  input  logic       auto_raw,
  output logic [1:0] led_sw,
  output logic       led_step,
  output logic       auto_active,
  output logic       lockout
);

  localparam int TW  = $clog2(TICK_DIV);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int PW  = (STEPS > 1) ? $clog2(STEPS) : 1;

  localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
  localparam logic [PW-1:0]  PH_LAST   = PW'(STEPS - 1);

  typedef enum logic [2:0] {
    MANUAL,
    AUTO_L,
    AUTO_R,
    AUTO_ON,
    AUTO_OFF
  } state_t;

  // Bit 2 is the auto switch, bits 1:0 the mode switches.
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     db;
  logic [DBW-1:0] db_cnt [3];
  logic [1:0]     sw_upd_bits;
  logic           sw_upd;

  logic [TW-1:0]  tick_cnt;
  logic           tick_clr;

  state_t         state;
  state_t         state_nxt;
  logic           lockout_nxt;
  logic [PW-1:0]  phase;
  logic [PW-1:0]  phase_nxt;

  // Two-flop synchronisers followed by per-bit stability counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      db    <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      sync1 <= {auto_raw, sw_raw};
      sync2 <= sync1;
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == db[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          db[i]     <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  // Flags the edge on which a debounced mode-switch bit is about to change, so
  // an override reaches MANUAL on the same edge the new switch value lands.
  always_comb begin
    sw_upd_bits = '0;
    for (int i = 0; i < 2; i++) begin
      sw_upd_bits[i] = (sync2[i] != db[i]) && (db_cnt[i] == DB_LAST);
    end
    sw_upd = |sw_upd_bits;
  end

  // Free-running step divider; restarted when auto begins so phase one is full length.
  always_ff @(posedge clk) begin
    if (rst || tick_clr) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + TW'(1);
    end
  end

  assign led_step = (tick_cnt == TICK_LAST);

  // State, lockout and phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= MANUAL;
      lockout <= 1'b0;
      phase   <= '0;
    end else begin
      state   <= state_nxt;
      lockout <= lockout_nxt;
      phase   <= phase_nxt;
    end
  end

  // Next-state logic: auto drop beats override, override beats phase advance.
  always_comb begin
    state_nxt   = state;
    lockout_nxt = lockout;
    phase_nxt   = phase;
    tick_clr    = 1'b0;
    case (state)
      MANUAL: begin
        if (!db[2]) begin
          lockout_nxt = 1'b0;
        end else if (!lockout) begin
          state_nxt = AUTO_L;
          phase_nxt = '0;
          tick_clr  = 1'b1;
        end
      end
      default: begin
        if (!db[2]) begin
          state_nxt = MANUAL;
        end else if (sw_upd) begin
          state_nxt   = MANUAL;
          lockout_nxt = 1'b1;
        end else if (led_step) begin
          if (phase == PH_LAST) begin
            phase_nxt = '0;
            case (state)
              AUTO_L:  state_nxt = AUTO_R;
              AUTO_R:  state_nxt = AUTO_ON;
              AUTO_ON: state_nxt = AUTO_OFF;
              default: state_nxt = AUTO_L;
            endcase
          end else begin
            phase_nxt = phase + PW'(1);
          end
        end
      end
    endcase
  end

  // Mode decode from registered state and registered debounced switches only.
  always_comb begin
    led_sw      = db[1:0];
    auto_active = (state != MANUAL);
    case (state)
      AUTO_L:   led_sw = 2'b01;
      AUTO_R:   led_sw = 2'b10;
      AUTO_ON:  led_sw = 2'b11;
      AUTO_OFF: led_sw = 2'b00;
      default:  led_sw = db[1:0];
    endcase
  end

endmodule

// File: tb/tb_led_mode_sequencer.sv
// Directed bench for led_mode_sequencer with TICK_DIV=4, DB_CYCLES=3, STEPS=2.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
// Expected values are hand-derived cycle counts from the block's timing rules.
module tb_led_mode_sequencer;

  logic       clk;
  logic       rst;
  logic [1:0] sw_raw;
  logic       auto_raw;
  logic [1:0] led_sw;
  logic       led_step;
  logic       auto_active;
  logic       lockout;

  int errors = 0;
  int checks = 0;

  logic [1:0] seq [4];
  logic       found;

  led_mode_sequencer #(
    .TICK_DIV (4),
    .DB_CYCLES(3),
    .STEPS    (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .auto_raw   (auto_raw),
    .led_sw     (led_sw),
    .led_step   (led_step),
    .auto_active(auto_active),
    .lockout    (lockout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk2(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    seq[0] = 2'b01;
    seq[1] = 2'b10;
    seq[2] = 2'b11;
    seq[3] = 2'b00;
    found  = 1'b0;

    // Reset with all raw inputs high.
    rst      = 1'b1;
    sw_raw   = 2'b11;
    auto_raw = 1'b1;
    tick();
    chk2("rst_led_sw", led_sw, 2'b00);
    chk1("rst_led_step", led_step, 1'b0);
    chk1("rst_auto_active", auto_active, 1'b0);
    chk1("rst_lockout", lockout, 1'b0);
    tick();
    chk2("rst_led_sw_2", led_sw, 2'b00);
    rst = 1'b0;
    tick();
    chk2("post_rst_led_sw", led_sw, 2'b00);
    chk1("post_rst_led_step", led_step, 1'b0);
    chk1("post_rst_auto_active", auto_active, 1'b0);
    chk1("post_rst_lockout", lockout, 1'b0);

    // Drop raw inputs; the single sampled high cycle must not propagate.
    sw_raw   = 2'b00;
    auto_raw = 1'b0;
    repeat (6) tick();
    chk2("settle_led_sw", led_sw, 2'b00);
    chk1("settle_auto_active", auto_active, 1'b0);

    // Debounce: new value lands on edge 5 after first sample.
    sw_raw = 2'b01;
    repeat (4) tick();
    chk2("db_edge4", led_sw, 2'b00);
    tick();
    chk2("db_edge5", led_sw, 2'b01);

    // Two-cycle glitch must be rejected.
    sw_raw = 2'b10;
    repeat (2) tick();
    sw_raw = 2'b01;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk2("glitch_hold", led_sw, 2'b01);
    end

    // Step strobe period in MANUAL.
    for (int i = 0; i < 8 && !found; i++) begin
      if (led_step) found = 1'b1;
      else tick();
    end
    chk1("tick_found", found, 1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 3; k++) begin
        tick();
        chk1("tick_low", led_step, 1'b0);
      end
      tick();
      chk1("tick_high", led_step, 1'b1);
    end

    // Auto schedule with switches at 00.
    sw_raw = 2'b00;
    repeat (6) tick();
    chk2("sw_clear", led_sw, 2'b00);
    auto_raw = 1'b1;
    repeat (5) tick();
    chk1("auto_wait", auto_active, 1'b0);
    tick();
    chk1("auto_enter", auto_active, 1'b1);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 8; k++) begin
        chk2("auto_seq", led_sw, seq[p]);
        chk1("auto_seq_active", auto_active, 1'b1);
        tick();
      end
    end
    chk2("auto_wrap", led_sw, 2'b01);
    chk1("auto_wrap_active", auto_active, 1'b1);

    // Manual override during AUTO_R.
    repeat (8) tick();
    chk2("in_auto_r", led_sw, 2'b10);
    sw_raw = 2'b11;
    repeat (4) tick();
    chk2("ovr_pending", led_sw, 2'b10);
    tick();
    chk2("ovr_led_sw", led_sw, 2'b11);
    chk1("ovr_lockout", lockout, 1'b1);
    chk1("ovr_auto_active", auto_active, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick();
      chk1("lock_hold_active", auto_active, 1'b0);
      chk1("lock_hold_lockout", lockout, 1'b1);
    end
    auto_raw = 1'b0;
    repeat (5) tick();
    chk1("lock_before_clear", lockout, 1'b1);
    tick();
    chk1("lock_cleared", lockout, 1'b0);
    auto_raw = 1'b1;
    repeat (5) tick();
    chk1("reenter_wait", auto_active, 1'b0);
    tick();
    chk1("reenter_active", auto_active, 1'b1);
    chk2("reenter_led_sw", led_sw, 2'b01);
    chk1("reenter_lockout", lockout, 1'b0);

    // Reset during AUTO_ON at phase count 1.
    repeat (16) tick();
    chk2("in_auto_on", led_sw, 2'b11);
    repeat (4) tick();
    chk2("auto_on_phase1", led_sw, 2'b11);
    chk1("auto_on_phase1_active", auto_active, 1'b1);
    rst = 1'b1;
    tick();
    chk2("midrst_led_sw", led_sw, 2'b00);
    chk1("midrst_auto_active", auto_active, 1'b0);
    chk1("midrst_lockout", lockout, 1'b0);
    chk1("midrst_led_step", led_step, 1'b0);
    rst = 1'b0;
    repeat (5) tick();
    chk1("postrst_wait", auto_active, 1'b0);
    chk2("postrst_manual_sw", led_sw, 2'b11);
    tick();
    chk1("postrst_reenter", auto_active, 1'b1);
    chk2("postrst_led_sw", led_sw, 2'b01);

    // Auto switch drop returns to MANUAL without lockout.
    auto_raw = 1'b0;
    repeat (5) tick();
    chk1("drop_wait", auto_active, 1'b1);
    tick();
    chk1("drop_active", auto_active, 1'b0);
    chk2("drop_led_sw", led_sw, 2'b11);
    chk1("drop_lockout", lockout, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
